// File: rtl/order_pkg.sv
// Shared types and constants for the pseudo-random limit-order stream generator.
package order_pkg;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_BURST  = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_e;

  // Galois form: shift right, fold the taps back in when a 1 falls off the end.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/order_stream_gen_lfsr16.sv
// 16-bit Galois LFSR that advances only when asked; reloads the seed on reset.
module lfsr16
  import order_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/order_stream_gen.sv
// Pseudo-random limit-order source with single / burst / continuous runs,
// a programmable inter-order gap and a valid/ready output handshake.
module order_stream_gen
  import order_pkg::*;
#(
  parameter int          PRICE_W = 8,
  parameter int          QTY_W   = 6,
  parameter int          ID_W    = 8,
  parameter int          GAP_W   = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [7:0]         burst_len,
  input  logic [GAP_W-1:0]   gap,
  input  logic [PRICE_W-1:0] price_base,
  input  logic [PRICE_W-1:0] price_mask,
  output logic               order_valid,
  input  logic               order_ready,
  output logic               order_side,
  output logic [PRICE_W-1:0] order_price,
  output logic [QTY_W-1:0]   order_qty,
  output logic [ID_W-1:0]    order_id,
  output logic               busy,
  output logic               done,
  output logic [15:0]        issued_count
);

  // An all-zero seed would lock the LFSR up forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic [7:0]         burst_len_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   timer_q;
  logic [7:0]         run_cnt_q;
  logic [7:0]         run_cnt_nxt;
  logic [15:0]        lfsr_val;
  logic               hs;
  logic               start_run;
  logic               end_run;
  logic               load_timer;
  logic               unused_lfsr;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  lfsr16 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .step     (hs),
    .seed     (SEED_EFF),
    .value    (lfsr_val)
  );

  assign order_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign hs          = order_valid & order_ready;
  assign run_cnt_nxt = run_cnt_q + 8'd1;
  assign unused_lfsr = ^lfsr_val;

  always_comb begin
    state_d    = state_q;
    start_run  = 1'b0;
    end_run    = 1'b0;
    load_timer = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_run = 1'b1;
          if (mode == MODE_BURST && burst_len == 8'd0) begin
            end_run = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          // Reserved mode 3 falls into the single-order case.
          if ((mode_q != MODE_BURST && mode_q != MODE_CONT) ||
              (mode_q == MODE_BURST && run_cnt_nxt == burst_len_q) ||
              (mode_q == MODE_CONT && stop)) begin
            end_run = 1'b1;
            state_d = IDLE;
          end else if (gap_q != '0) begin
            load_timer = 1'b1;
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        if (mode_q == MODE_CONT && stop) begin
          end_run = 1'b1;
          state_d = IDLE;
        end else if (timer_q == GAP_W'(1)) begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fields are a pure function of the LFSR, so they hold while the consumer stalls.
  always_comb begin
    order_side  = 1'b0;
    order_price = '0;
    order_qty   = '0;
    if (state_q == ISSUE) begin
      order_side  = lfsr_val[0];
      order_price = price_base + (lfsr_val[PRICE_W:1] & price_mask);
      order_qty   = (lfsr_val[15 -: QTY_W] == '0) ? QTY_W'(1) : lfsr_val[15 -: QTY_W];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_SINGLE;
      run_cnt_q    <= '0;
      timer_q      <= '0;
      order_id     <= '0;
      issued_count <= '0;
      done         <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= end_run;
      if (start_run) begin
        mode_q    <= mode;
        run_cnt_q <= '0;
      end else if (hs) begin
        run_cnt_q <= run_cnt_nxt;
      end
      if (hs) begin
        order_id     <= order_id + ID_W'(1);
        issued_count <= sat_inc16(issued_count);
      end
      if (load_timer) begin
        timer_q <= gap_q;
      end else if (state_q == GAP) begin
        timer_q <= timer_q - GAP_W'(1);
      end
    end
  end

  // Run configuration is captured once per start and never reset.
  always_ff @(posedge CLOCK_50) begin
    if (start_run) begin
      burst_len_q <= burst_len;
      gap_q       <= gap;
    end
  end

endmodule

// File: tb/tb_order_stream_gen.sv
// Scoreboard bench for order_stream_gen: expected orders are queued when a run is started.
module tb_order_stream_gen;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  burst_len;
  logic [15:0] gap;
  logic [7:0]  pbase;
  logic [7:0]  pmask;
  logic        order_valid;
  logic        order_ready;
  logic        order_side;
  logic [7:0]  order_price;
  logic [5:0]  order_qty;
  logic [7:0]  order_id;
  logic        busy;
  logic        done;
  logic [15:0] issued_count;

  always #5 clk = ~clk;

  order_stream_gen dut (
    .CLOCK_50     (clk),
    .Reset        (Reset),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .burst_len    (burst_len),
    .gap          (gap),
    .price_base   (pbase),
    .price_mask   (pmask),
    .order_valid  (order_valid),
    .order_ready  (order_ready),
    .order_side   (order_side),
    .order_price  (order_price),
    .order_qty    (order_qty),
    .order_id     (order_id),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count)
  );

  typedef struct {
    logic       side;
    logic [7:0] price;
    logic [5:0] qty;
    logic [7:0] id;
  } ord_t;

  ord_t        sb[$];
  ord_t        exp_o;
  ord_t        held;
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_hs_cyc = -100;
  int          exp_gap = 0;
  int          inv = 0;
  bit          gap_pending = 0;
  bit          stall_prev = 0;
  bit          chk_done_lat = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  m_id;
  int          m_issued;
  int          d0;
  int          p0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: handshakes pop the scoreboard, stalls must hold, gaps must match.
  always @(negedge clk) begin
    if (Reset) begin
      stall_prev  = 0;
      gap_pending = 0;
      inv         = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", order_valid, 1);
        check("stall_fields", {order_side, order_price, order_qty, order_id},
              {held.side, held.price, held.qty, held.id});
      end
      if (order_valid) begin
        if (gap_pending) check("gap_len", inv, exp_gap);
        gap_pending = 0;
        inv = 0;
      end else if (busy) begin
        inv++;
        gap_pending = 1;
      end else begin
        gap_pending = 0;
        inv = 0;
      end
      stall_prev = order_valid && !order_ready;
      held.side  = order_side;
      held.price = order_price;
      held.qty   = order_qty;
      held.id    = order_id;
      if (order_valid && order_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_o = sb.pop_front();
          check("ord_side", order_side, exp_o.side);
          check("ord_price", order_price, exp_o.price);
          check("ord_qty", order_qty, exp_o.qty);
          check("ord_id", order_id, exp_o.id);
        end
        pops++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (chk_done_lat) check("done_lat", cyc - last_hs_cyc, 1);
        check("done_busy", busy, 0);
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lfsr   = 16'hACE1;
    m_id     = 8'd0;
    m_issued = 0;
    sb.delete();
  endtask

  task automatic push_orders(input int n);
    ord_t e;
    logic lsb;
    for (int i = 0; i < n; i++) begin
      e.side  = m_lfsr[0];
      e.price = pbase + 8'((m_lfsr >> 1) & {8'h00, pmask});
      e.qty   = m_lfsr[15:10];
      if (e.qty == 6'd0) e.qty = 6'd1;
      e.id    = m_id;
      sb.push_back(e);
      lsb    = m_lfsr[0];
      m_lfsr = m_lfsr >> 1;
      if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
      m_id++;
      m_issued++;
    end
  endtask

  // Inputs are scrambled after start so a mid-run change would show up.
  task automatic pulse_start(input logic [1:0] md, input logic [7:0] bl, input logic [15:0] g);
    mode = md;
    burst_len = bl;
    gap = g;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    burst_len = 8'hFF;
    gap = 16'd9;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pops < n && k < budget) begin
      step_clk();
      k++;
    end
    if (pops < n) check("timeout_pops", pops, n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step_clk();
      k++;
    end
    if (busy) check("timeout_idle", busy, 0);
    step_clk();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, order_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_id"}, order_id, 0);
    check({tag, "_issued"}, issued_count, 0);
    check({tag, "_side"}, order_side, 0);
    check({tag, "_price"}, order_price, 0);
    check({tag, "_qty"}, order_qty, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; burst_len = 8'd0; gap = 16'd0;
    pbase = 8'd100; pmask = 8'h0F; order_ready = 1'b1;
    model_reset();
    step_clk();
    step_clk();
    check_reset_outputs("rst");
    Reset = 1'b0;
    step_clk();

    // Single order with known field values from the seed
    exp_gap = 0; chk_done_lat = 1; d0 = done_cnt;
    push_orders(1);
    pulse_start(2'd0, 8'd0, 16'd0);
    check("t1_valid", order_valid, 1);
    check("t1_side", order_side, 1);
    check("t1_price", order_price, 100);
    check("t1_qty", order_qty, 43);
    check("t1_id", order_id, 0);
    wait_idle(20);
    check("t1_done", done_cnt - d0, 1);
    check("t1_issued", issued_count, 1);
    check("t1_busy", busy, 0);

    // Burst of 5 with 3-cycle gaps
    d0 = done_cnt; p0 = pops; exp_gap = 3;
    push_orders(5);
    pulse_start(2'd1, 8'd5, 16'd3);
    wait_idle(100);
    check("t2_pops", pops - p0, 5);
    check("t2_done", done_cnt - d0, 1);
    check("t2_sb", sb.size(), 0);
    check("t2_id", order_id, 32'(m_id));
    check("t2_issued", issued_count, m_issued);

    // Burst of 4, back-to-back, consumer stalls every other cycle
    d0 = done_cnt; p0 = pops; exp_gap = 0;
    push_orders(4);
    pulse_start(2'd1, 8'd4, 16'd0);
    for (int k = 0; k < 100 && busy; k++) begin
      order_ready = ~order_ready;
      step_clk();
    end
    order_ready = 1'b1;
    step_clk();
    check("t3_pops", pops - p0, 4);
    check("t3_done", done_cnt - d0, 1);
    check("t3_sb", sb.size(), 0);

    // Continuous; stop raised during a 3-cycle stall
    d0 = done_cnt; p0 = pops;
    push_orders(4);
    pulse_start(2'd2, 8'd0, 16'd0);
    wait_pops(p0 + 3, 50);
    order_ready = 1'b0;
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t4_hold", order_valid, 1);
      step_clk();
    end
    order_ready = 1'b1;
    step_clk();
    stop = 1'b0;
    check("t4_busy", busy, 0);
    step_clk();
    check("t4_pops", pops - p0, 4);
    check("t4_done", done_cnt - d0, 1);
    check("t4_sb", sb.size(), 0);

    // Zero-length burst: done the cycle after start, no order
    chk_done_lat = 0; d0 = done_cnt; p0 = pops;
    pulse_start(2'd1, 8'd0, 16'd0);
    check("t5_done", done, 1);
    check("t5_valid", order_valid, 0);
    check("t5_busy", busy, 0);
    step_clk();
    check("t5_done_once", done, 0);
    check("t5_pops", pops - p0, 0);
    chk_done_lat = 1;

    // Start during a continuous run is ignored
    d0 = done_cnt; p0 = pops;
    push_orders(6);
    pulse_start(2'd2, 8'd0, 16'd0);
    wait_pops(p0 + 2, 50);
    mode = 2'd0;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    check("t5_still_busy", busy, 1);
    wait_pops(p0 + 5, 50);
    stop = 1'b1;
    wait_idle(20);
    stop = 1'b0;
    check("t5_run_pops", pops - p0, 6);
    check("t5_run_done", done_cnt - d0, 1);
    check("t5_sb", sb.size(), 0);

    // Reset in the middle of a gap
    d0 = done_cnt; p0 = pops; exp_gap = 2;
    push_orders(10);
    pulse_start(2'd2, 8'd0, 16'd2);
    wait_pops(p0 + 3, 100);
    check("t6_in_gap", {busy, order_valid}, 2'b10);
    Reset = 1'b1;
    step_clk();
    check_reset_outputs("t6rst");
    Reset = 1'b0;
    model_reset();
    step_clk();
    check("t6_no_done", done_cnt - d0, 0);

    // Long continuous run: order_id wraps, issued_count keeps going
    d0 = done_cnt; p0 = pops; exp_gap = 0;
    push_orders(259);
    pulse_start(2'd2, 8'd0, 16'd0);
    wait_pops(p0 + 258, 400);
    stop = 1'b1;
    wait_idle(20);
    stop = 1'b0;
    check("t6_pops", pops - p0, 259);
    check("t6_id_wrap", order_id, 3);
    check("t6_issued", issued_count, 259);
    check("t6_done", done_cnt - d0, 1);
    check("t6_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
